// File: rtl/matrix_weight_sequencer_if.sv
// matrix_weight_sequencer_if: weight stream (s_*) plus matrix cell port (m_*).
// master = sequencer side: drives s_ready and all m_* except m_rdata.
// slave  = stream source / matrix side: drives s_valid, s_data, m_rdata.
interface matrix_weight_sequencer_if #(parameter int N = 8);
    logic                s_valid, s_ready;
    logic [31:0]         s_data;
    logic                m_wready, m_wr_match, m_vh;
    logic [$clog2(N):0]  m_s_addr, m_d_addr;
    logic [31:0]         m_wdata, m_rdata;
    modport master(input s_valid, s_data, m_rdata,
                   output s_ready, m_wready, m_wr_match, m_s_addr, m_d_addr, m_vh, m_wdata);
    modport slave(output s_valid, s_data, m_rdata,
                  input s_ready, m_wready, m_wr_match, m_s_addr, m_d_addr, m_vh, m_wdata);
endinterface

// File: rtl/matrix_weight_sequencer.sv
// matrix_weight_sequencer: walks every Ising matrix cell, writing stream words or verifying read-back.
// Ports: clk, axi_rst (sync, active-high); start/mode/abort control; bus = stream + matrix port;
// busy/done status; err_count, first_err_valid/s/d/vh report verify mismatches.
module matrix_weight_sequencer #(
    parameter int N        = 8,
    parameter int DIAGONAL = 1,
    parameter int DUAL_VH  = 1,
    parameter int READ_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                         clk,
    input  logic                         axi_rst,
    input  logic                         start,
    input  logic                         mode,
    input  logic                         abort,
    matrix_weight_sequencer_if.master    bus,
    output logic                         busy,
    output logic                         done,
    output logic [CNT_W-1:0]             err_count,
    output logic                         first_err_valid,
    output logic [$clog2(N)-1:0]         first_err_s,
    output logic [$clog2(N)-1:0]         first_err_d,
    output logic                         first_err_vh
);
    localparam int AW = $clog2(N);
    typedef enum logic [2:0] {IDLE, FETCH, WRITE, READ, CHECK, DONE} state_t;
    state_t        state;
    logic [AW-1:0] s, d, n_s, n_d;
    logic          vh, n_vh, two, last, mode_r;
    logic [31:0]   word, rsample;
    logic [1:0]    lat;
    assign bus.m_s_addr = {1'b0, s};
    assign bus.m_d_addr = {1'b0, d};
    assign bus.m_vh     = vh;
    assign bus.m_wdata  = word;
    // coupled cells take a second (vh=1) word; shorted diagonal cells never do
    always_comb begin
        two  = DUAL_VH != 0 && !(DIAGONAL != 0 && s == d);
        last = s == AW'(N - 1) && d == AW'(N - 1) && (vh || !two);
        n_vh = two && !vh;
        n_s  = (n_vh || d != AW'(N - 1)) ? s : s + 1'b1;
        n_d  = n_vh ? d : d != AW'(N - 1) ? d + 1'b1 : DIAGONAL != 0 ? s + 1'b1 : '0;
    end
    always_ff @(posedge clk) begin
        if (axi_rst) begin
            state           <= IDLE;
            s               <= '0;
            d               <= '0;
            vh              <= 1'b0;
            word            <= '0;
            rsample         <= '0;
            lat             <= '0;
            mode_r          <= 1'b0;
            bus.s_ready     <= 1'b0;
            bus.m_wready    <= 1'b0;
            bus.m_wr_match  <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            err_count       <= '0;
            first_err_valid <= 1'b0;
            first_err_s     <= '0;
            first_err_d     <= '0;
            first_err_vh    <= 1'b0;
        end else if (abort && state != IDLE) begin
            state          <= IDLE;
            bus.s_ready    <= 1'b0;
            bus.m_wready   <= 1'b0;
            bus.m_wr_match <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start && !abort) begin
                    state           <= FETCH;
                    busy            <= 1'b1;
                    bus.s_ready     <= 1'b1;
                    mode_r          <= mode;
                    err_count       <= '0;
                    first_err_valid <= 1'b0;
                    s               <= '0;
                    d               <= '0;
                    vh              <= 1'b0;
                end
                FETCH: if (bus.s_valid) begin
                    word           <= bus.s_data;
                    bus.s_ready    <= 1'b0;
                    bus.m_wr_match <= 1'b1;
                    bus.m_wready   <= !mode_r;
                    lat            <= '0;
                    state          <= mode_r ? READ : WRITE;
                end
                READ: if (lat == 2'(READ_LAT - 1)) begin
                    rsample        <= bus.m_rdata;
                    bus.m_wr_match <= 1'b0;
                    state          <= CHECK;
                end else lat <= lat + 1'b1;
                WRITE, CHECK: begin
                    if (state == CHECK && rsample != word) begin
                        if (err_count != '1) err_count <= err_count + 1'b1;
                        if (!first_err_valid) begin
                            first_err_valid <= 1'b1;
                            first_err_s     <= s;
                            first_err_d     <= d;
                            first_err_vh    <= vh;
                        end
                    end
                    bus.m_wready   <= 1'b0;
                    bus.m_wr_match <= 1'b0;
                    if (last) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                    end else begin
                        s           <= n_s;
                        d           <= n_d;
                        vh          <= n_vh;
                        bus.s_ready <= 1'b1;
                        state       <= FETCH;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_matrix_weight_sequencer.sv
// tb_matrix_weight_sequencer: two N=4 sequencers (folded dual-vh / unfolded single-vh) against a cell-list model.
module tb_matrix_weight_sequencer;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    logic [1:0]        sv = '0, start_i = '0, mode_i = '0, abort_i = '0;
    logic [1:0][31:0]  sd = '0, rd, wd;
    logic [1:0]        sr, wr, mt, vh_o, busy_o, done_o, fev, fevh, outsum;
    logic [1:0][2:0]   sa, da;
    logic [1:0][1:0]   fes, fed;
    logic [15:0]       eca;
    logic [1:0]        ecb;
    logic [1:0][15:0]  ec;
    logic [31:0]       mem [2][128];
    int rcnt [2], viol [2], dcnt [2];
    int wk [2][$];
    int rk [2][$];
    logic [31:0] wdl [2][$];
    int cells [$];
    logic [31:0] ws [$];
    int exp_err, exp_first, passed = 0, total = 0;

    matrix_weight_sequencer_if #(.N(4)) ifa ();
    matrix_weight_sequencer_if #(.N(4)) ifb ();
    matrix_weight_sequencer #(.N(4), .DIAGONAL(1), .DUAL_VH(1), .READ_LAT(1), .CNT_W(16)) dut_a (
        .clk(clk), .axi_rst(rst), .start(start_i[0]), .mode(mode_i[0]), .abort(abort_i[0]), .bus(ifa.master),
        .busy(busy_o[0]), .done(done_o[0]), .err_count(eca), .first_err_valid(fev[0]),
        .first_err_s(fes[0]), .first_err_d(fed[0]), .first_err_vh(fevh[0]));
    matrix_weight_sequencer #(.N(4), .DIAGONAL(0), .DUAL_VH(0), .READ_LAT(2), .CNT_W(2)) dut_b (
        .clk(clk), .axi_rst(rst), .start(start_i[1]), .mode(mode_i[1]), .abort(abort_i[1]), .bus(ifb.master),
        .busy(busy_o[1]), .done(done_o[1]), .err_count(ecb), .first_err_valid(fev[1]),
        .first_err_s(fes[1]), .first_err_d(fed[1]), .first_err_vh(fevh[1]));

    assign ifa.s_valid = sv[0];
    assign ifa.s_data  = sd[0];
    assign ifa.m_rdata = rd[0];
    assign ifb.s_valid = sv[1];
    assign ifb.s_data  = sd[1];
    assign ifb.m_rdata = rd[1];
    assign sr   = {ifb.s_ready, ifa.s_ready};
    assign wr   = {ifb.m_wready, ifa.m_wready};
    assign mt   = {ifb.m_wr_match, ifa.m_wr_match};
    assign vh_o = {ifb.m_vh, ifa.m_vh};
    assign sa[0] = ifa.m_s_addr;
    assign sa[1] = ifb.m_s_addr;
    assign da[0] = ifa.m_d_addr;
    assign da[1] = ifb.m_d_addr;
    assign wd[0] = ifa.m_wdata;
    assign wd[1] = ifb.m_wdata;
    assign ec[0] = eca;
    assign ec[1] = {14'b0, ecb};
    assign outsum[0] = |{sr[0], wr[0], mt[0], sa[0], da[0], vh_o[0], wd[0], busy_o[0], done_o[0],
                         ec[0], fev[0], fes[0], fed[0], fevh[0]};
    assign outsum[1] = |{sr[1], wr[1], mt[1], sa[1], da[1], vh_o[1], wd[1], busy_o[1], done_o[1],
                         ec[1], fev[1], fes[1], fed[1], fevh[1]};

    // matrix read data only becomes valid after the address has been held READ_LAT-1 cycles
    always_comb begin
        rd = '0;
        for (int u = 0; u < 2; u++)
            rd[u] = (rcnt[u] >= u) ? mem[u][{sa[u], da[u], vh_o[u]}] : ~mem[u][{sa[u], da[u], vh_o[u]}];
    end
    always @(posedge clk)
        for (int u = 0; u < 2; u++) rcnt[u] <= (mt[u] && !wr[u]) ? rcnt[u] + 1 : 0;

    always @(negedge clk)
        for (int u = 0; u < 2; u++) begin
            if (wr[u] && !mt[u]) viol[u]++;
            if (sr[u] && mt[u]) viol[u]++;
            if (wr[u]) begin
                wk[u].push_back(int'({sa[u], da[u], vh_o[u]}));
                wdl[u].push_back(wd[u]);
            end
            if (mt[u] && !wr[u] && rcnt[u] == 0) rk[u].push_back(int'({sa[u], da[u], vh_o[u]}));
            if (done_o[u]) dcnt[u]++;
        end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // kind: 0 matrix matches stream, 1 cell (2,1,0)=0xDEAD, 2 all cells wrong, 3 random corruption
    task automatic prep(input int u, input int kind);
        logic [31:0] w;
        cells.delete();
        ws.delete();
        for (int s = 0; s < 4; s++)
            for (int d = (u == 0 ? s : 0); d < 4; d++)
                for (int v = 0; v < ((u == 0 && s == d) ? 1 : (u == 0 ? 2 : 1)); v++)
                    cells.push_back(s * 16 + d * 2 + v);
        for (int k = 0; k < cells.size(); k++) begin
            w = $urandom;
            if (w == 32'hDEAD) w = 0;
            ws.push_back(w);
            mem[u][cells[k]] = kind == 2 ? ~w :
                (kind == 3 && $urandom_range(2) == 0) ? w ^ (32'h1 << $urandom_range(31)) : w;
        end
        if (kind == 1) mem[u][34] = 32'hDEAD;
        exp_err = 0;
        exp_first = -1;
        for (int k = 0; k < cells.size(); k++)
            if (mem[u][cells[k]] != ws[k]) begin
                exp_err++;
                if (exp_first < 0) exp_first = cells[k];
            end
        if (exp_err > (u == 1 ? 3 : 65535)) exp_err = (u == 1 ? 3 : 65535);
    endtask

    // stop_kind: 1 abort once stop_at words accepted, 2 reset at the next READ cycle after that
    task automatic feed(input int u, input bit md, input int vmode, input int stop_at, input int stop_kind,
                        output int acc, output int cyc);
        bit fin = 0;
        acc = 0;
        cyc = 0;
        @(negedge clk);
        start_i[u] = 1'b1;
        mode_i[u] = md;
        while (!fin && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            start_i[u] = (vmode == 2) && ($urandom_range(3) == 0);
            if (cyc == 1) chk("busy_after_start", busy_o[u], 1);
            if (done_o[u]) fin = 1;
            else if (stop_at > 0 && acc >= stop_at && (stop_kind == 1 || (mt[u] && !wr[u]))) begin
                sv[u] = 1'b0;
                start_i[u] = 1'b0;
                if (stop_kind == 1) abort_i[u] = 1'b1;
                else rst = 1'b1;
                @(negedge clk);
                abort_i[u] = 1'b0;
                rst = 1'b0;
                fin = 1;
            end else begin
                sv[u] = (acc < ws.size()) && (vmode == 0 ? 1'b1 : vmode == 1 ? ((cyc / 3) % 2 == 0) :
                        ($urandom_range(1) == 1));
                sd[u] = acc < ws.size() ? ws[acc] : $urandom;
                #1 if (sv[u] && sr[u]) acc++;
            end
        end
        start_i[u] = 1'b0;
        sv[u] = 1'b0;
        chk("pass_terminated", fin, 1);
    endtask

    task automatic check_writes(input int u, input int wb, input int n);
        int bad = 0;
        chk("write_count", wk[u].size() - wb, n);
        for (int k = 0; k < n && wb + k < wk[u].size(); k++)
            if (wk[u][wb + k] != cells[k] || wdl[u][wb + k] != ws[k]) bad++;
        chk("write_sequence", bad, 0);
    endtask

    task automatic check_verify(input int u, input int rb, input int wb);
        int bad = 0;
        chk("err_count", ec[u], exp_err);
        chk("first_err_valid", fev[u], exp_first >= 0);
        if (exp_first >= 0) begin
            chk("first_err_s", fes[u], exp_first >> 4);
            chk("first_err_d", fed[u], (exp_first >> 1) & 3);
            chk("first_err_vh", fevh[u], exp_first & 1);
        end
        chk("read_count", rk[u].size() - rb, cells.size());
        for (int k = 0; k < cells.size() && rb + k < rk[u].size(); k++)
            if (rk[u][rb + k] != cells[k]) bad++;
        chk("read_sequence", bad, 0);
        chk("no_write_in_verify", wk[u].size() - wb, 0);
    endtask

    task automatic full_pass(input int u, input bit md, input int vmode, input int kind);
        int acc, cyc, wb, rb, db;
        prep(u, kind);
        wb = wk[u].size();
        rb = rk[u].size();
        db = dcnt[u];
        feed(u, md, vmode, 0, 0, acc, cyc);
        if (!md && vmode == 0) chk("cycles_to_done", cyc - 1, 2 * cells.size());
        @(negedge clk);
        chk("busy_after_done", busy_o[u], 0);
        chk("done_pulses", dcnt[u] - db, 1);
        if (md) check_verify(u, rb, wb);
        else check_writes(u, wb, cells.size());
        chk("protocol_violations", viol[u], 0);
    endtask

    initial begin
        int acc, cyc, wb, db;
        repeat (3) @(negedge clk);
        chk("reset_outputs_a", outsum[0], 0);
        chk("reset_outputs_b", outsum[1], 0);
        rst = 1'b0;
        @(negedge clk);
        full_pass(0, 0, 0, 0);
        full_pass(0, 0, 1, 0);
        full_pass(1, 1, 0, 1);
        full_pass(0, 1, 2, 3);
        prep(0, 0);
        wb = wk[0].size();
        db = dcnt[0];
        feed(0, 0, 2, 5, 1, acc, cyc);
        chk("abort_wready", wr[0], 0);
        chk("abort_wr_match", mt[0], 0);
        chk("abort_busy", busy_o[0], 0);
        chk("abort_s_ready", sr[0], 0);
        repeat (3) @(negedge clk);
        chk("abort_no_done", dcnt[0] - db, 0);
        check_writes(0, wb, 5);
        full_pass(0, 0, 0, 0);
        prep(1, 3);
        feed(1, 1, 2, 3, 2, acc, cyc);
        chk("midread_reset_b", outsum[1], 0);
        chk("midread_reset_a", outsum[0], 0);
        @(negedge clk);
        full_pass(1, 1, 2, 0);
        full_pass(1, 1, 0, 2);
        full_pass(1, 1, 1, 3);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/matrix_weight_sequencer.md
Name: matrix_weight_sequencer

Overview:
- Autonomous programming/verification engine for the recursive Ising coupling matrix.
- Walks every physical cell of an N-spin matrix, folded or unfolded, and drives the matrix write port with weights taken from a valid/ready stream.
- In verify mode it reads each cell back, compares it against the stream and records mismatches.
- Sits between the AXI register front-end and the matrix, replacing per-word software addressing.

Parameters:
- N, 8: spin count; power of 2, ≥2.
- DIAGONAL, 1: 1 = folded matrix. Only cells with d≥s are visited, and s==d cells are shorted cells. 0 = all N×N cells are coupled cells.
- DUAL_VH, 1: 1 = each coupled cell takes two words (vh=0, then vh=1). 0 = one word with vh=0. Shorted cells always take one word with vh=0.
- READ_LAT, 1: cycles from address presentation to a valid m_rdata sample; 1..4.
- CNT_W, 16: width of err_count.

Ports:
- clk  in  1  clock
- axi_rst  in  1  reset; synchronous, active-high
- start  in  1  begin a pass; sampled only in IDLE
- mode  in  1  0 = write, 1 = verify; latched at start
- abort  in  1  terminate the pass
- s_valid  in  1  stream word valid
- s_ready  out  1  stream word accepted when s_valid&s_ready
- s_data  in  32  weight (write mode) or expected value (verify mode)
- m_wready  out  1  matrix write strobe
- m_wr_match  out  1  matrix cell select
- m_s_addr  out  $clog2(N)+1  source address; MSB always 0
- m_d_addr  out  $clog2(N)+1  destination address; MSB always 0
- m_vh  out  1  weight half select
- m_wdata  out  32  write data
- m_rdata  in  32  matrix read data
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at pass completion
- err_count  out  CNT_W  verify mismatches; saturating
- first_err_valid  out  1  first_err_* fields hold data
- first_err_s  out  $clog2(N)  s of the first mismatch
- first_err_d  out  $clog2(N)  d of the first mismatch
- first_err_vh  out  1  vh of the first mismatch

Behaviour:
- Reset (axi_rst=1 at a clk edge): all outputs 0, state IDLE, addresses 0. Reset mid-pass abandons the pass with no done pulse.
- Visit order: s = 0..N-1 ascending. For each s, d runs from (DIAGONAL ? s : 0) to N-1. Within a coupled cell with DUAL_VH=1, vh=0 is visited before vh=1.
- Words per pass:
  - DIAGONAL=1: N + (N(N-1)/2)·(1+DUAL_VH).
  - DIAGONAL=0: N²·(1+DUAL_VH).
- States: IDLE, FETCH, WRITE, READ, CHECK, DONE.
- IDLE: busy=0. start → FETCH on the next cycle with busy=1. Also clears err_count and first_err_valid, latches mode and sets the address to the first cell.
- FETCH: s_ready=1. Holds until a handshake; s_valid low stalls indefinitely with m_wready=m_wr_match=0. On handshake, s_data is registered, then → WRITE (mode 0) or → READ (mode 1).
- WRITE: exactly one cycle with m_wready=1, m_wr_match=1, current addresses and m_vh, m_wdata = registered word. Then advance → FETCH, or → DONE after the last cell. Throughput is one word per 2 cycles.
- READ: m_wr_match=1, m_wready=0, addresses and m_vh stable for READ_LAT cycles. m_rdata is sampled on the last cycle, then → CHECK.
- CHECK: one cycle, strobes low. If the sample ≠ expected:
  - err_count increments, saturating at 2^CNT_W-1.
  - If first_err_valid=0, capture s/d/vh and set first_err_valid.
  - Then advance → FETCH, or → DONE.
- DONE: done=1 for one cycle, busy=0, → IDLE. err_count and first_err_* hold until the next start or reset.
- Advance: vh toggles first; d wraps after N-1 to the next s start value. The last cell is s=N-1, d=N-1, final vh.
- abort: highest priority after reset. From any non-IDLE state → IDLE on the next cycle. Strobes drop that cycle, no done pulse, counters retained.
- start while busy is ignored. start and abort together in IDLE: abort wins and the pass does not begin.
- m_wready is never high without m_wr_match. At most one write per accepted word.

Test Plan:
- N=4, DIAGONAL=1, DUAL_VH=1, mode 0, continuous s_valid, data 0..15 → 16 write strobes in 32 cycles. (s,d,vh) sequence is (0,0,0),(0,1,0),(0,1,1),(0,2,0)…(3,3,0), with wdata matching stream order. done pulses once, then busy=0.
- Same config, s_valid toggled every 3 cycles → identical strobe sequence. No strobe occurs while FETCH is stalled, and s_ready never drops mid-handshake.
- N=4, DIAGONAL=0, DUAL_VH=0, mode 1, READ_LAT=2. Behavioural matrix returns expected values except (2,1)=0xDEAD → err_count=1, first_err = (2,1,0), 16 reads, no m_wready ever.
- abort asserted after the 5th accepted word in write mode → strobes low next cycle, busy=0, no done. A following start restarts at (0,0,0).
- axi_rst asserted during READ → all outputs 0 the next cycle. A later start completes a normal pass.
- CNT_W=2, verify with every cell mismatching → err_count saturates at 3. first_err stays at (0,0,0).
